// File: rtl/regwb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regwb_arbiter
//  Description : Write-back arbiter and register scoreboard for an
//                NREG x DW register bank.
//                - Two write-back sources share the bank's single write port:
//                  ALU and the memory load unit. Each cycle one of them is
//                  granted, with round-robin fairness when both request.
//                - The winner's write is registered and presented to the
//                  bank one cycle later.
//                - A busy bit per register records a pending write. The
//                  issue logic uses it to stall on RAW and WAW hazards.
//
//  Optional feature:
//                REGWB_BYPASS_EN - when defined, a register whose write is
//                on the bank port this cycle (wr_en=1, wr_addr) does not
//                cause a stall. Sources are forwarded from wr_data by the
//                issue unit. The destination check is also dropped, because
//                the new reservation's set overrides the same-edge clear.
//
//  Ports       :
//    clk, rst                      clock, synchronous active-high reset
//    iss_valid/src1/src2/dest      issue request and its register operands
//    iss_stall                     combinational hazard stall to issue unit
//    alu_req/addr/data, alu_gnt    ALU write-back request and grant
//    mem_req/addr/data, mem_gnt    load write-back request and grant
//    wr_en/wr_addr/wr_data         registered write port to register bank
//    busy_vec                      scoreboard, bit i = write pending to reg i
//    err_unres                     sticky: write granted to unreserved reg
//
//  Revision    : 1.0 - initial release
// ============================================================================
module regwb_arbiter #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    // issue side
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_src1,
    input  logic [AW-1:0]     iss_src2,
    input  logic [AW-1:0]     iss_dest,
    output logic              iss_stall,
    // ALU write-back source
    input  logic              alu_req,
    input  logic [AW-1:0]     alu_addr,
    input  logic [DW-1:0]     alu_data,
    output logic              alu_gnt,
    // load write-back source
    input  logic              mem_req,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_data,
    output logic              mem_gnt,
    // register bank write port
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [DW-1:0]     wr_data,
    // scoreboard and status
    output logic [2**AW-1:0]  busy_vec,
    output logic              err_unres
);

    localparam int c_NREG = 2**AW;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // r_last_alu: 1 when the ALU won the most recent contended arbitration.
    // Reset to 0 so the ALU is favoured at the first contention.
    logic                r_last_alu;
    logic                r_wr_en;
    logic [AW-1:0]       r_wr_addr;
    logic [DW-1:0]       r_wr_data;
    logic [c_NREG-1:0]   r_busy;
    logic                r_err;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                w_contend;
    logic                w_alu_gnt;
    logic                w_mem_gnt;
    logic                w_any_gnt;
    logic [AW-1:0]       w_win_addr;
    logic [DW-1:0]       w_win_data;
    logic                w_src1_busy;
    logic                w_src2_busy;
    logic                w_dest_busy;
    logic                w_stall;
    logic                w_issue;
    logic                w_unres;
    logic [c_NREG-1:0]   w_busy_nxt;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    // A lone requester always wins. Under contention the source that lost
    // last time wins now, which alternates grants under sustained contention.
    always_comb begin
        w_contend  = alu_req & mem_req;
        w_alu_gnt  = alu_req & (~mem_req | ~r_last_alu);
        w_mem_gnt  = mem_req & (~alu_req |  r_last_alu);
        w_any_gnt  = w_alu_gnt | w_mem_gnt;
        w_win_addr = w_alu_gnt ? alu_addr : mem_addr;
        w_win_data = w_alu_gnt ? alu_data : mem_data;
        // The busy bit is checked as seen in the grant cycle.
        w_unres    = w_any_gnt & ~r_busy[w_win_addr];
    end

    assign alu_gnt = w_alu_gnt;
    assign mem_gnt = w_mem_gnt;

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    always_comb begin
`ifdef REGWB_BYPASS_EN
        // The register being written right now frees at this edge. Its
        // value is forwarded from wr_data, so it is not a hazard.
        w_src1_busy = r_busy[iss_src1] & ~(r_wr_en & (iss_src1 == r_wr_addr));
        w_src2_busy = r_busy[iss_src2] & ~(r_wr_en & (iss_src2 == r_wr_addr));
        // Safe because a set beats a same-edge clear of the same register.
        w_dest_busy = r_busy[iss_dest] & ~(r_wr_en & (iss_dest == r_wr_addr));
`else
        w_src1_busy = r_busy[iss_src1];
        w_src2_busy = r_busy[iss_src2];
        w_dest_busy = r_busy[iss_dest];
`endif
        w_stall = iss_valid & (w_src1_busy | w_src2_busy | w_dest_busy);
        w_issue = iss_valid & ~w_stall;
    end

    assign iss_stall = w_stall;

    // ------------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------------
    // Each bit clears when its write is on the bank port. It sets when an
    // accepted issue reserves it. The set term is ORed last, so a
    // reservation made in the same cycle as the clear survives.
    generate
        for (genvar gi = 0; gi < c_NREG; gi++) begin : g_busy
            logic w_set;
            logic w_clr;
            assign w_set = w_issue & (iss_dest == AW'(gi));
            assign w_clr = r_wr_en & (r_wr_addr == AW'(gi));
            assign w_busy_nxt[gi] = w_set | (r_busy[gi] & ~w_clr);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // A grant in the reset cycle is dropped here. No write follows.
            r_last_alu <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= '0;
            r_err      <= 1'b0;
        end else begin
            // The pointer moves only when both sources competed.
            if (w_contend) begin
                r_last_alu <= w_alu_gnt;
            end
            r_wr_en <= w_any_gnt;
            // Address and data hold when there is no grant. They are only
            // meaningful while wr_en is high.
            if (w_any_gnt) begin
                r_wr_addr <= w_win_addr;
                r_wr_data <= w_win_data;
            end
            r_busy <= w_busy_nxt;
            if (w_unres) begin
                r_err <= 1'b1;
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy_vec  = r_busy;
    assign err_unres = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regwb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regwb_arbiter
//  Description : Self-checking bench for regwb_arbiter. It applies directed
//                scenarios followed by randomized traffic. All results are
//                compared against a behavioural scoreboard model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regwb_arbiter;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            iss_valid;
    logic [AW-1:0]   iss_src1, iss_src2, iss_dest;
    logic            iss_stall;
    logic            alu_req;
    logic [AW-1:0]   alu_addr;
    logic [DW-1:0]   alu_data;
    logic            alu_gnt;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic            mem_gnt;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NREG-1:0] busy_vec;
    logic            err_unres;

    regwb_arbiter #(.DW(DW), .AW(AW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_src1  (iss_src1),
        .iss_src2  (iss_src2),
        .iss_dest  (iss_dest),
        .iss_stall (iss_stall),
        .alu_req   (alu_req),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_gnt   (alu_gnt),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_gnt   (mem_gnt),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy_vec  (busy_vec),
        .err_unres (err_unres)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a set of reserved registers, a pending bank write,
    // the preferred source for the next tie, and a sticky error flag.
    // ------------------------------------------------------------------------
    bit m_busy [NREG];
    bit m_pref_mem;
    bit m_wr_en;
    int m_wr_addr;
    int m_wr_data;
    bit m_err;
    bit g_alu, g_mem;   // grants the model predicted in the last step

`ifdef REGWB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic logic [NREG-1:0] m_busy_vec();
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit m_hazard(int r);
        if (BYPASS && m_wr_en && m_wr_addr == r) return 1'b0;
        return m_busy[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_pref_mem = 1'b0;
        m_wr_en    = 1'b0;
        m_wr_addr  = 0;
        m_wr_data  = 0;
        m_err      = 1'b0;
    endtask

    // One clock cycle: check the DUT against the model at the falling edge.
    // Then advance the model and return just after the rising edge.
    task automatic step();
        bit e_alu, e_mem, e_stall, gnt;
        int waddr, wdata;
        @(negedge clk);
        e_alu   = alu_req && (!mem_req || !m_pref_mem);
        e_mem   = mem_req && (!alu_req ||  m_pref_mem);
        e_stall = iss_valid && (m_hazard(iss_src1) || m_hazard(iss_src2) || m_hazard(iss_dest));
        check_eq("alu_gnt",   alu_gnt,   e_alu);
        check_eq("mem_gnt",   mem_gnt,   e_mem);
        check_eq("iss_stall", iss_stall, e_stall);
        check_eq("wr_en",     wr_en,     m_wr_en);
        if (m_wr_en) begin
            check_eq("wr_addr", wr_addr, m_wr_addr);
            check_eq("wr_data", wr_data, m_wr_data);
        end
        check_eq("busy_vec",  busy_vec,  m_busy_vec());
        check_eq("err_unres", err_unres, m_err);
        g_alu = e_alu;
        g_mem = e_mem;
        if (rst) begin
            model_reset();
        end else begin
            gnt   = e_alu || e_mem;
            waddr = e_alu ? int'(alu_addr) : int'(mem_addr);
            wdata = e_alu ? int'(alu_data) : int'(mem_data);
            if (gnt && !m_busy[waddr]) m_err = 1'b1;
            if (m_wr_en) m_busy[m_wr_addr] = 1'b0;
            if (iss_valid && !e_stall) m_busy[iss_dest] = 1'b1;
            if (alu_req && mem_req) m_pref_mem = e_alu;
            m_wr_en = gnt;
            if (gnt) begin
                m_wr_addr = waddr;
                m_wr_data = wdata;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; iss_valid = 0; iss_src1 = 0; iss_src2 = 0; iss_dest = 0;
        alu_req = 0; alu_addr = 0; alu_data = 0;
        mem_req = 0; mem_addr = 0; mem_data = 0;
    endtask

    task automatic issue(input int s1, input int s2, input int d);
        iss_valid = 1; iss_src1 = AW'(s1); iss_src2 = AW'(s2); iss_dest = AW'(d);
    endtask

    // Prefer busy targets so most random writes are legal.
    function automatic logic [AW-1:0] pick_addr();
        int c[$];
        for (int i = 0; i < NREG; i++) if (m_busy[i]) c.push_back(i);
        if (c.size() > 0 && $urandom_range(0, 7) != 0)
            return AW'(c[$urandom_range(0, c.size() - 1)]);
        return AW'($urandom_range(0, NREG - 1));
    endfunction

    int ca [5] = '{1, 5, 5, 7, 7};   // ALU address per contention cycle
    int cm [5] = '{2, 2, 6, 6, 6};   // MEM address per contention cycle
    bit cg [5] = '{1, 0, 1, 0, 1};   // 1 = ALU wins that cycle
    bit cmr[5] = '{1, 1, 1, 1, 0};   // MEM requesting that cycle

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        idle();

        // Reset state
        #1;
        check_eq("rst_wr_en",  wr_en,     0);
        check_eq("rst_addr",   wr_addr,   0);
        check_eq("rst_data",   wr_data,   0);
        check_eq("rst_busy",   busy_vec,  0);
        check_eq("rst_err",    err_unres, 0);
        check_eq("idle_agnt",  alu_gnt,   0);
        check_eq("idle_mgnt",  mem_gnt,   0);
        check_eq("idle_stall", iss_stall, 0);
        step();

        // Reserve r3; a reader of r3 stalls
        issue(0, 0, 3);
        step();
        issue(3, 0, 4);
        #1;
        check_eq("busy_r3",   busy_vec,  8'h08);
        check_eq("raw_stall", iss_stall, 1);
        step();

        // ALU writes r3 = A5
        idle();
        alu_req = 1; alu_addr = 3; alu_data = 8'hA5;
        #1;
        check_eq("alu_gnt_T", alu_gnt, 1);
        step();
        idle();
        issue(3, 0, 4);
        #1;
        check_eq("wr_en_T1",   wr_en,   1);
        check_eq("wr_addr_T1", wr_addr, 3);
        check_eq("wr_data_T1", wr_data, 8'hA5);
        check_eq("stall_T1",   iss_stall, BYPASS ? 1'b0 : 1'b1);
        step();
        #1;
        check_eq("busy_T2",  busy_vec[3], 0);
        check_eq("stall_T2", iss_stall,   0);
        step();
        idle();

        // Sustained contention
        for (int d = 1; d <= 7; d++) begin
            if (d == 1 || d == 2 || d == 5 || d == 6 || d == 7) begin
                issue(0, 0, d);
                step();
            end
        end
        idle();
        for (int k = 0; k < 5; k++) begin
            alu_req = 1; alu_addr = AW'(ca[k]); alu_data = DW'(8'h10 + k);
            mem_req = cmr[k]; mem_addr = AW'(cm[k]); mem_data = DW'(8'h20 + k);
            #1;
            check_eq("cont_agnt", alu_gnt, cg[k]);
            check_eq("cont_mgnt", mem_gnt, !cg[k]);
            if (k > 0) check_eq("cont_wr_en", wr_en, 1);
            step();
        end
        idle();
        step();
        check_eq("cont_err", err_unres, 0);

        // Reserve r5 again, then write r5 while re-issuing dest r5
        issue(0, 0, 5);
        step();
        idle();
        alu_req = 1; alu_addr = 5; alu_data = 8'h3C;
        step();
        idle();
        issue(0, 0, 5);
        step();
        idle();
        #1;
        check_eq("setwin_busy5", busy_vec[5], BYPASS ? 1'b1 : 1'b0);
        check_eq("setwin_err",   err_unres,   0);
        step();

        // Load to unreserved r6
        mem_req = 1; mem_addr = 6; mem_data = 8'h66;
        step();
        idle();
        #1;
        check_eq("unres_wr",   wr_en,     1);
        check_eq("unres_err",  err_unres, 1);
        repeat (3) step();
        check_eq("unres_sticky", err_unres, 1);

        // Fill the scoreboard, then reset during a grant
        for (int d = 0; d < NREG; d++) begin
            if (!m_busy[d]) begin
                issue(d, d, d);
                step();
            end
        end
        idle();
        step();
        check_eq("full_busy", busy_vec, 8'hFF);
        rst = 1; alu_req = 1; alu_addr = 0; alu_data = 8'h99;
        #1;
        check_eq("rst_gnt", alu_gnt, 1);
        step();
        idle();
        #1;
        check_eq("post_rst_wr_en", wr_en,    0);
        check_eq("post_rst_busy",  busy_vec, 0);
        check_eq("post_rst_agnt",  alu_gnt,  0);
        check_eq("post_rst_mgnt",  mem_gnt,  0);
        step();

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!alu_req || g_alu) begin
                alu_req  = ($urandom_range(0, 2) != 0);
                alu_addr = pick_addr();
                alu_data = DW'($urandom);
            end
            if (!mem_req || g_mem) begin
                mem_req  = ($urandom_range(0, 2) != 0);
                mem_addr = pick_addr();
                mem_data = DW'($urandom);
            end
            iss_valid = $urandom_range(0, 1);
            iss_src1  = AW'($urandom_range(0, NREG - 1));
            iss_src2  = AW'($urandom_range(0, NREG - 1));
            iss_dest  = AW'($urandom_range(0, NREG - 1));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
